// File: rtl/pong_pkg.sv
// Shared encodings and small arithmetic helpers for the pong game core.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SND_NONE = 2'd0,
    SND_WALL = 2'd1,
    SND_BAT  = 2'd2,
    SND_MISS = 2'd3
  } snd_e;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // True when rows [a0, a0+alen-1] and [b0, b0+blen-1] share at least one row.
  function automatic logic rows_overlap(input int a0, input int alen,
                                        input int b0, input int blen);
    return (a0 <= b0 + blen - 1) && (b0 <= a0 + alen - 1);
  endfunction

endpackage

// File: rtl/pong_bat_ctrl.sv
// One bat: human displacement or ball-tracking autoplayer, clamped to the field,
// plus a flag remembering whether the bat moved down on its last update.
module pong_bat_ctrl
  import pong_pkg::*;
#(
  parameter int YW        = 9,
  parameter int Y0        = 50,
  parameter int Y1        = 277,
  parameter int BAT_H     = 16,
  parameter int BALL_H    = 4,
  parameter int AUTO_FAST = 4,
  parameter int AUTO_SLOW = 1,
  parameter int INIT_Y    = 156
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          upd_i,
  input  logic          human_i,
  input  logic          approach_i,
  input  logic [YW-1:0] move_i,
  input  logic [YW-1:0] ball_y_i,
  output logic [YW-1:0] y_o,
  output logic          dir_o
);

  localparam int YMAX = Y1 - BAT_H + 1;
  localparam int TOFF = BALL_H / 2 - BAT_H / 2;

  logic [YW-1:0]        y_q, y_d;
  logic                 dir_q;
  logic signed [YW+1:0] cur_s, mv_s, tgt_s, gap_s, step_s, raw_s;

  assign cur_s  = $signed({2'b00, y_q});
  assign mv_s   = $signed({{2{move_i[YW-1]}}, move_i});
  assign tgt_s  = $signed({2'b00, ball_y_i}) + (YW+2)'(TOFF);
  assign gap_s  = tgt_s - cur_s;
  assign step_s = approach_i ? (YW+2)'(AUTO_FAST) : (YW+2)'(AUTO_SLOW);

  // NOTE: every path assigns raw_s and y_d, so no latch is inferred.
  always_comb begin
    if (human_i)                raw_s = cur_s - mv_s;
    else if (gap_s >= step_s)   raw_s = cur_s + step_s;
    else if (gap_s <= -step_s)  raw_s = cur_s - step_s;
    else                        raw_s = tgt_s;
    y_d = YW'(clamp(int'(raw_s), Y0, YMAX));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_q   <= YW'(INIT_Y);
      dir_q <= 1'b0;
    end else if (upd_i) begin
      y_q   <= y_d;
      dir_q <= (y_d > y_q);
    end
  end

  assign y_o   = y_q;
  assign dir_o = dir_q;

endmodule

// File: rtl/pong_engine.sv
// Frame-rate pong core: ball physics, serve/play/point/over sequencing, scoring
// and sound events, all resolved from coordinates once per unpaused frame.
module pong_engine
  import pong_pkg::*;
#(
  parameter int YW           = 9,
  parameter int XW           = 7,
  parameter int FIELD_X0     = 22,
  parameter int FIELD_X1     = 105,
  parameter int FIELD_Y0     = 50,
  parameter int FIELD_Y1     = 277,
  parameter int LBAT_X       = 26,
  parameter int RBAT_X       = 102,
  parameter int BAT_H        = 16,
  parameter int BALL_H       = 4,
  parameter int WIN_SCORE    = 15,
  parameter int SERVE_FRAMES = 50,
  parameter int SND_FRAMES   = 8,
  parameter int AUTO_FAST    = 4,
  parameter int AUTO_SLOW    = 1
) (
  input  logic                             glb_clk,
  input  logic                             reset,
  input  logic                             frame_tick,
  input  logic                             pause,
  input  logic                             restart,
  input  logic                             lbat_human,
  input  logic                             rbat_human,
  input  logic [YW-1:0]                    lbat_move,
  input  logic [YW-1:0]                    rbat_move,
  output logic [XW-1:0]                    ball_x,
  output logic [YW-1:0]                    ball_y,
  output logic [YW-1:0]                    lbat_y,
  output logic [YW-1:0]                    rbat_y,
  output logic [$clog2(WIN_SCORE+1)-1:0]   l_score,
  output logic [$clog2(WIN_SCORE+1)-1:0]   r_score,
  output logic [1:0]                       state,
  output logic                             winner,
  output logic [1:0]                       snd_evt,
  output logic                             snd_active
);

  localparam int SW        = $clog2(WIN_SCORE + 1);
  localparam int CW        = $clog2(SERVE_FRAMES + 1);
  localparam int NW        = $clog2(SND_FRAMES + 1);
  localparam int CX        = (FIELD_X0 + FIELD_X1) / 2;
  localparam int CY        = (FIELD_Y0 + FIELD_Y1 - BALL_H + 1) / 2;
  localparam int BAT_Y0    = (FIELD_Y0 + FIELD_Y1 - BAT_H + 1) / 2;
  localparam int BALL_YMAX = FIELD_Y1 - BALL_H + 1;

  logic          upd, auto_both, game_won;
  logic [XW-1:0] ball_x_q;
  logic [YW-1:0] ball_y_q, ball_y_d;
  logic          xdir_q, ydir_q, ydir_d, yspd_q;
  logic [SW-1:0] l_score_q, r_score_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          winner_q;
  snd_e          snd_evt_q, evt;
  logic [NW-1:0] snd_cnt_q;
  logic          snd_active_q;
  logic [YW-1:0] lbat_y_w, rbat_y_w;
  logic          ldir_w, rdir_w;
  logic          wall, lhit, rhit, lmiss, rmiss, hit_bat_dir;
  int            ny;

  assign upd       = frame_tick & ~pause;
  assign auto_both = ~lbat_human & ~rbat_human;
  assign game_won  = (l_score_q == SW'(WIN_SCORE)) || (r_score_q == SW'(WIN_SCORE));

  pong_bat_ctrl #(
    .YW(YW), .Y0(FIELD_Y0), .Y1(FIELD_Y1), .BAT_H(BAT_H), .BALL_H(BALL_H),
    .AUTO_FAST(AUTO_FAST), .AUTO_SLOW(AUTO_SLOW), .INIT_Y(BAT_Y0)
  ) u_lbat (
    .clk_i(glb_clk), .rst_i(reset), .upd_i(upd), .human_i(lbat_human),
    .approach_i(~xdir_q), .move_i(lbat_move), .ball_y_i(ball_y_q),
    .y_o(lbat_y_w), .dir_o(ldir_w)
  );

  pong_bat_ctrl #(
    .YW(YW), .Y0(FIELD_Y0), .Y1(FIELD_Y1), .BAT_H(BAT_H), .BALL_H(BALL_H),
    .AUTO_FAST(AUTO_FAST), .AUTO_SLOW(AUTO_SLOW), .INIT_Y(BAT_Y0)
  ) u_rbat (
    .clk_i(glb_clk), .rst_i(reset), .upd_i(upd), .human_i(rbat_human),
    .approach_i(xdir_q), .move_i(rbat_move), .ball_y_i(ball_y_q),
    .y_o(rbat_y_w), .dir_o(rdir_w)
  );

  // Vertical step with wall bounce; a landing exactly on the wall row also bounces.
  always_comb begin
    ny       = ydir_q ? int'(ball_y_q) + 1 + int'(yspd_q)
                      : int'(ball_y_q) - 1 - int'(yspd_q);
    ball_y_d = YW'(ny);
    ydir_d   = ydir_q;
    wall     = 1'b0;
    if (!ydir_q && ny <= FIELD_Y0) begin
      ball_y_d = YW'(FIELD_Y0);
      ydir_d   = 1'b1;
      wall     = 1'b1;
    end else if (ydir_q && ny + BALL_H - 1 >= FIELD_Y1) begin
      ball_y_d = YW'(BALL_YMAX);
      ydir_d   = 1'b0;
      wall     = 1'b1;
    end
  end

  assign lhit = !xdir_q && (ball_x_q == XW'(LBAT_X + 1)) &&
                rows_overlap(int'(ball_y_q), BALL_H, int'(lbat_y_w), BAT_H);
  assign rhit = xdir_q && (ball_x_q == XW'(RBAT_X - 1)) &&
                rows_overlap(int'(ball_y_q), BALL_H, int'(rbat_y_w), BAT_H);
  assign lmiss       = !xdir_q && (ball_x_q == XW'(FIELD_X0));
  assign rmiss       = xdir_q && (ball_x_q == XW'(FIELD_X1));
  assign hit_bat_dir = lhit ? ldir_w : rdir_w;

  always_comb begin
    evt = SND_NONE;
    if (state_q == ST_PLAY) begin
      if (lmiss || rmiss)     evt = SND_MISS;
      else if (lhit || rhit)  evt = SND_BAT;
      else if (wall)          evt = SND_WALL;
    end
  end

  always_ff @(posedge glb_clk or posedge reset) begin
    if (reset) begin
      ball_x_q     <= XW'(CX);
      ball_y_q     <= YW'(CY);
      xdir_q       <= 1'b0;
      ydir_q       <= 1'b0;
      yspd_q       <= 1'b1;
      l_score_q    <= '0;
      r_score_q    <= '0;
      state_q      <= ST_SERVE;
      cnt_q        <= CW'(SERVE_FRAMES);
      winner_q     <= 1'b0;
      snd_evt_q    <= SND_NONE;
      snd_cnt_q    <= '0;
      snd_active_q <= 1'b0;
    end else if (upd) begin
      if (evt != SND_NONE) begin
        snd_evt_q    <= evt;
        snd_cnt_q    <= NW'(SND_FRAMES);
        snd_active_q <= 1'b1;
      end else if (snd_cnt_q != '0) begin
        snd_cnt_q    <= snd_cnt_q - 1'b1;
        snd_active_q <= (snd_cnt_q != NW'(1));
      end

      case (state_q)
        ST_SERVE: begin
          if (cnt_q <= CW'(1)) begin
            state_q <= ST_PLAY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_PLAY: begin
          ball_y_q <= ball_y_d;
          ydir_q   <= ydir_d;
          if (lhit || rhit) begin
            xdir_q <= ~xdir_q;
            yspd_q <= ydir_d ^ hit_bat_dir;
          end else if (lmiss) begin
            r_score_q <= r_score_q + 1'b1;
            state_q   <= ST_POINT;
          end else if (rmiss) begin
            l_score_q <= l_score_q + 1'b1;
            state_q   <= ST_POINT;
          end else begin
            ball_x_q <= xdir_q ? ball_x_q + 1'b1 : ball_x_q - 1'b1;
          end
        end
        ST_POINT: begin
          // xdir is left untouched, so the next serve heads toward whoever conceded.
          cnt_q <= CW'(SERVE_FRAMES);
          if (game_won) begin
            state_q  <= ST_OVER;
            winner_q <= (r_score_q == SW'(WIN_SCORE));
          end else begin
            state_q  <= ST_SERVE;
            ball_x_q <= XW'(CX);
            ball_y_q <= YW'(CY);
          end
        end
        ST_OVER: begin
          if (restart || (auto_both && cnt_q <= CW'(1))) begin
            l_score_q <= '0;
            r_score_q <= '0;
            state_q   <= ST_SERVE;
            ball_x_q  <= XW'(CX);
            ball_y_q  <= YW'(CY);
            cnt_q     <= CW'(SERVE_FRAMES);
          end else if (auto_both) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign lbat_y     = lbat_y_w;
  assign rbat_y     = rbat_y_w;
  assign l_score    = l_score_q;
  assign r_score    = r_score_q;
  assign state      = state_q;
  assign winner     = winner_q;
  assign snd_evt    = snd_evt_q;
  assign snd_active = snd_active_q;

endmodule

// File: tb/tb_pong_engine.sv
// Randomised bench for pong_engine: an integer game model is advanced on every
// frame update and compared with all outputs each cycle, plus pinned scenarios.
module tb_pong_engine;

  localparam int X0 = 22, X1 = 105, Y0 = 50, Y1 = 277;
  localparam int LBX = 26, RBX = 102, BAT_H = 16, BALL_H = 4;
  localparam int WIN = 15, SERVE = 50, SND = 8;
  localparam int CX = 63, CY = 162, BAT_Y0 = 156;

  logic       glb_clk = 1'b0;
  logic       reset, frame_tick, pause, restart, lbat_human, rbat_human;
  logic [8:0] lbat_move, rbat_move;
  logic [6:0] ball_x;
  logic [8:0] ball_y, lbat_y, rbat_y;
  logic [3:0] l_score, r_score;
  logic [1:0] state, snd_evt;
  logic       winner, snd_active;

  int total = 0;
  int bad   = 0;

  // Model of the game, in plain integers.
  int m_bx, m_by, m_lb, m_rb, m_xd, m_yd, m_ys, m_ls, m_rs;
  int m_st, m_cnt, m_win, m_evt, m_snd, m_ldir, m_rdir;

  pong_engine dut (
    .glb_clk(glb_clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
    .restart(restart), .lbat_human(lbat_human), .rbat_human(rbat_human),
    .lbat_move(lbat_move), .rbat_move(rbat_move), .ball_x(ball_x), .ball_y(ball_y),
    .lbat_y(lbat_y), .rbat_y(rbat_y), .l_score(l_score), .r_score(r_score),
    .state(state), .winner(winner), .snd_evt(snd_evt), .snd_active(snd_active)
  );

  always #5 glb_clk = ~glb_clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: dut=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int bat_next(input int y, input bit human, input int mv,
                                  input bit approach, input int by);
    int tgt, step, n;
    if (human) begin
      n = y - mv;
    end else begin
      tgt  = by + BALL_H / 2 - BAT_H / 2;
      step = approach ? 4 : 1;
      if (y < tgt) n = (y + step < tgt) ? y + step : tgt;
      else         n = (y - step > tgt) ? y - step : tgt;
    end
    return clampi(n, Y0, Y1 - BAT_H + 1);
  endfunction

  task automatic model_reset();
    m_bx = CX; m_by = CY; m_lb = BAT_Y0; m_rb = BAT_Y0;
    m_xd = 0; m_yd = 0; m_ys = 1; m_ls = 0; m_rs = 0;
    m_st = 0; m_cnt = SERVE; m_win = 0; m_evt = 0; m_snd = 0; m_ldir = 0; m_rdir = 0;
  endtask

  task automatic new_game();
    m_ls = 0; m_rs = 0; m_st = 0; m_bx = CX; m_by = CY; m_cnt = SERVE;
  endtask

  task automatic model_step();
    int  nlb, nrb, ny, nyd, evt;
    bit  hit_l, hit_r, wall;
    nlb = bat_next(m_lb, lbat_human, int'($signed(lbat_move)), m_xd == 0, m_by);
    nrb = bat_next(m_rb, rbat_human, int'($signed(rbat_move)), m_xd == 1, m_by);
    evt = 0;
    case (m_st)
      0: begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_st = 1;
      end
      1: begin
        wall = 0;
        nyd  = m_yd;
        ny   = m_yd ? m_by + 1 + m_ys : m_by - 1 - m_ys;
        if (m_yd == 0 && ny <= Y0) begin
          ny = Y0; nyd = 1; wall = 1;
        end else if (m_yd == 1 && ny + BALL_H - 1 >= Y1) begin
          ny = Y1 - BALL_H + 1; nyd = 0; wall = 1;
        end
        hit_l = (m_xd == 0) && (m_bx == LBX + 1) &&
                (m_by <= m_lb + BAT_H - 1) && (m_lb <= m_by + BALL_H - 1);
        hit_r = (m_xd == 1) && (m_bx == RBX - 1) &&
                (m_by <= m_rb + BAT_H - 1) && (m_rb <= m_by + BALL_H - 1);
        if (hit_l || hit_r) begin
          m_xd = 1 - m_xd;
          m_ys = nyd ^ (hit_l ? m_ldir : m_rdir);
          evt  = 2;
        end else if (m_xd == 0 && m_bx == X0) begin
          m_rs++; m_st = 2; evt = 3;
        end else if (m_xd == 1 && m_bx == X1) begin
          m_ls++; m_st = 2; evt = 3;
        end else begin
          m_bx = m_bx + (m_xd == 1 ? 1 : -1);
        end
        if (evt == 0 && wall) evt = 1;
        m_by = ny;
        m_yd = nyd;
      end
      2: begin
        m_cnt = SERVE;
        if (m_ls == WIN || m_rs == WIN) begin
          m_st = 3; m_win = (m_rs == WIN) ? 1 : 0;
        end else begin
          m_st = 0; m_bx = CX; m_by = CY;
        end
      end
      default: begin
        if (restart) new_game();
        else if (!lbat_human && !rbat_human) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) new_game();
        end
      end
    endcase
    m_ldir = (nlb > m_lb) ? 1 : 0;
    m_rdir = (nrb > m_rb) ? 1 : 0;
    m_lb = nlb;
    m_rb = nrb;
    if (evt != 0) begin
      m_evt = evt; m_snd = SND;
    end else if (m_snd > 0) begin
      m_snd--;
    end
  endtask

  // Single compare process: advance the model on each edge, then check every output.
  always @(posedge glb_clk) begin
    if (reset) model_reset();
    else if (frame_tick && !pause) model_step();
    #1;
    check("ball_x", ball_x, m_bx);
    check("ball_y", ball_y, m_by);
    check("lbat_y", lbat_y, m_lb);
    check("rbat_y", rbat_y, m_rb);
    check("l_score", l_score, m_ls);
    check("r_score", r_score, m_rs);
    check("state", state, m_st);
    check("winner", winner, m_win);
    check("snd_evt", snd_evt, m_evt);
    check("snd_active", snd_active, (m_snd != 0) ? 1 : 0);
  end

  task automatic cyc(input bit tk, input bit pz);
    @(negedge glb_clk);
    frame_tick = tk;
    pause      = pz;
    @(posedge glb_clk);
    #2;
  endtask

  function automatic logic [8:0] rand_move();
    if ($urandom_range(0, 19) == 0) return 9'($urandom_range(0, 511));
    return 9'(int'($urandom_range(0, 16)) - 8);
  endfunction

  task automatic rand_cyc();
    @(negedge glb_clk);
    frame_tick = ($urandom_range(0, 3) != 0);
    pause      = ($urandom_range(0, 15) == 0);
    lbat_move  = rand_move();
    rbat_move  = rand_move();
    @(posedge glb_clk);
    #2;
  endtask

  task automatic run_until_over(input int budget);
    for (int i = 0; i < budget && m_st != 3; i++) rand_cyc();
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; pause = 1'b0; restart = 1'b0;
    lbat_human = 1'b0; rbat_human = 1'b0; lbat_move = '0; rbat_move = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge glb_clk);
    check("rst_ball_x", ball_x, 63);
    check("rst_ball_y", ball_y, 162);
    check("rst_lbat", lbat_y, 156);
    check("rst_rbat", rbat_y, 156);
    check("rst_state", state, 0);
    check("rst_snd_evt", snd_evt, 0);
    check("rst_snd_active", snd_active, 0);
    reset = 1'b0;

    // Human clamp at both ends of the field.
    lbat_human = 1'b1;
    lbat_move  = 9'd100;
    cyc(1'b1, 1'b0);
    check("human_up_56", lbat_y, 56);
    cyc(1'b1, 1'b0);
    check("human_clamp_top", lbat_y, 50);
    lbat_move = 9'h100;
    cyc(1'b1, 1'b0);
    check("human_clamp_bottom", lbat_y, 262);
    lbat_move = '0;

    // Serve timing: 50 unpaused frames, paused ticks do not count.
    repeat (17) cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b1, 1'b1);
    repeat (29) cyc(1'b1, 1'b0);
    check("serve_frame49", state, 0);
    cyc(1'b1, 1'b0);
    check("serve_frame50_play", state, 1);
    check("serve_ball_x", ball_x, 63);
    check("serve_ball_y", ball_y, 162);
    cyc(1'b1, 1'b0);
    check("first_move_x", ball_x, 62);
    check("first_move_y", ball_y, 160);

    // Random human left vs autoplayer right until the game ends.
    run_until_over(30000);
    check("phaseA_over", state, 3);
    check("phaseA_top_score", (l_score > r_score) ? l_score : r_score, 15);

    // OVER with a human player stays put; then attract mode restarts after 50 frames.
    repeat (100) rand_cyc();
    check("over_hold", state, 3);
    lbat_human = 1'b0;
    repeat (49) cyc(1'b1, 1'b0);
    check("attract_frame49", state, 3);
    cyc(1'b1, 1'b0);
    check("attract_serve", state, 0);
    check("attract_l_score", l_score, 0);
    check("attract_r_score", r_score, 0);
    check("attract_ball_x", ball_x, 63);

    // Both autoplayers rally.
    repeat (3000) rand_cyc();

    // Asynchronous reset mid-cycle.
    @(negedge glb_clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ball_x", ball_x, 63);
    check("async_rst_state", state, 0);
    check("async_rst_l_score", l_score, 0);
    check("async_rst_snd_active", snd_active, 0);
    @(negedge glb_clk);
    reset = 1'b0;

    // Autoplayer left vs random human right, then an explicit restart.
    rbat_human = 1'b1;
    run_until_over(30000);
    check("phaseD_over", state, 3);
    restart = 1'b1;
    cyc(1'b1, 1'b0);
    restart = 1'b0;
    check("restart_state", state, 0);
    check("restart_l_score", l_score, 0);
    check("restart_r_score", r_score, 0);
    repeat (5) cyc(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
